column_fill_tracker: RTL and testbench
======================================

// Module: column_fill_tracker
// PURPOSE
//  Tracks the token height of every column on the game board in one block.
//  It accepts one drop or one undo request per cycle with a registered accept/reject response.
//  It also reports per-column full flags, the total token count and board-full.
//  Sits between the move controller (which issues drops/undos) and the win checker / display,
//  which read the heights and the landing row.
// PARAMETERS
//  NUM_COLS  7   number of board columns (1..15)
//  NUM_ROWS  6   tokens per column before the column is full (1..15)
//  COL_W     4   width of column-index inputs; indices >= NUM_COLS are illegal
//  CNT_W     $clog2(NUM_ROWS+1)           per-column height width (derived)
//  TOT_W     $clog2(NUM_COLS*NUM_ROWS+1)  total-count width (derived)
// PORTS
//  clk          in   1               single clock, all state on posedge
//  reset        in   1               synchronous, active-high; clears all state
//  clear        in   1               synchronous new-game clear; lower priority than reset
//  drop_valid   in   1               request to drop a token into drop_col this cycle
//  drop_col     in   COL_W           target column of drop
//  undo_valid   in   1               request to remove the top token of undo_col
//  undo_col     in   COL_W           target column of undo
//  drop_accept  out  1               1-cycle pulse: previous-cycle drop applied
//  drop_reject  out  1               1-cycle pulse: previous-cycle drop refused
//  drop_row     out  CNT_W           landing row of last accepted drop (0 = bottom)
//  undo_accept  out  1               1-cycle pulse: previous-cycle undo applied
//  undo_reject  out  1               1-cycle pulse: previous-cycle undo refused
//  heights      out  NUM_COLS*CNT_W  packed heights; column c at [c*CNT_W +: CNT_W]
//  col_full     out  NUM_COLS        bit c = (height[c] == NUM_ROWS)
//  total_count  out  TOT_W           sum of all heights
//  board_full   out  1               total_count == NUM_COLS*NUM_ROWS
// BEHAVIOUR
//  - Reset: all heights, total_count and drop_row are 0.
//    All pulses (accept/reject) are 0. col_full = 0 and board_full = 0.
//  - Priority each cycle: reset > clear > undo > drop.
//  - clear: heights and total go to 0 next cycle. drop_row goes to 0.
//    Any drop/undo in that cycle is ignored and produces no accept/reject pulse.
//  - Latency: a request sampled on edge N updates heights/total and pulses its response on edge N.
//    The pulse is visible for exactly the cycle after N, then returns to 0 unless re-asserted.
//  - Drop is accepted iff all of the following hold:
//    drop_col < NUM_COLS, col_full[drop_col] == 0, and undo_valid == 0.
//    On accept: height[drop_col] += 1, total += 1, drop_row <= old height[drop_col].
//    Otherwise: drop_reject pulses and no state changes (drop_row holds).
//  - Undo is accepted iff undo_col < NUM_COLS and height[undo_col] != 0.
//    On accept: height -= 1, total -= 1. Otherwise undo_reject pulses and no change.
//  - Simultaneous drop_valid and undo_valid: the undo is evaluated.
//    The drop is always rejected (drop_reject pulses), even if the columns differ.
//  - Saturation: a height never exceeds NUM_ROWS and never wraps below 0.
//    total_count never exceeds NUM_COLS*NUM_ROWS.
//  - col_full, board_full and total_count are registered state or pure functions of registered state.
//    They are glitch-free and change only on clk edges.
//  - A request on the same cycle reset or clear is asserted is discarded; no pulse results.
//  - With no request, all outputs hold and pulses are 0.
// TESTING
//  1. After reset, 6 drops into col 1 (defaults) -> drop_row 0..5, accept x6, height[1]=6, col_full[1]=1.
//  2. 7th drop into full col 1 -> drop_reject=1 for one cycle, height[1]=6, total_count=6.
//  3. drop_col=7 and drop_col=15 -> drop_reject, no state change.
//     undo_col=3 on empty col -> undo_reject, heights unchanged.
//  4. Same cycle: drop col 2 + undo col 1 (h1=6) -> undo_accept, drop_reject, h1=5, h2=0, total=5.
//  5. Fill all 42 cells -> board_full=1 after the 42nd accept.
//     Next: clear -> all heights 0, board_full=0, no pulses that cycle.
//  6. Assert reset mid-sequence, together with drop_valid -> next cycle all zero, no accept/reject pulse.
//     Re-run with NUM_COLS=4, NUM_ROWS=3: full at 3, board_full at 12.

Source files
------------

// File: rtl/column_fill_tracker.sv
// Per-column token height tracker for a drop-style game board.
// Accepts one drop or undo per cycle and answers with a registered accept/reject pulse.
module column_fill_tracker #(
  parameter int NUM_COLS = 7,
  parameter int NUM_ROWS = 6,
  parameter int COL_W    = 4,
  parameter int CNT_W    = $clog2(NUM_ROWS + 1),
  parameter int TOT_W    = $clog2(NUM_COLS * NUM_ROWS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      drop_valid,
  input  logic [COL_W-1:0]          drop_col,
  input  logic                      undo_valid,
  input  logic [COL_W-1:0]          undo_col,
  output logic                      drop_accept,
  output logic                      drop_reject,
  output logic [CNT_W-1:0]          drop_row,
  output logic                      undo_accept,
  output logic                      undo_reject,
  output logic [NUM_COLS*CNT_W-1:0] heights,
  output logic [NUM_COLS-1:0]       col_full,
  output logic [TOT_W-1:0]          total_count,
  output logic                      board_full
);

  localparam logic [CNT_W-1:0] ROWS_C  = CNT_W'(NUM_ROWS);
  localparam logic [TOT_W-1:0] CELLS_C = TOT_W'(NUM_COLS * NUM_ROWS);

  logic [NUM_COLS-1:0]       sel_drop;
  logic [NUM_COLS-1:0]       sel_undo;
  logic [NUM_COLS-1:0]       full_vec;
  logic [NUM_COLS-1:0]       empty_vec;
  logic [NUM_COLS-1:0]       inc_vec;
  logic [NUM_COLS-1:0]       dec_vec;
  logic [NUM_COLS*CNT_W-1:0] heights_q;

  logic                      drop_ok;
  logic                      undo_ok;
  logic [CNT_W-1:0]          drop_old_h;

  logic [TOT_W-1:0]          total_d, total_q;
  logic [CNT_W-1:0]          drop_row_d, drop_row_q;
  logic                      drop_accept_d, drop_accept_q;
  logic                      drop_reject_d, drop_reject_q;
  logic                      undo_accept_d, undo_accept_q;
  logic                      undo_reject_d, undo_reject_q;

  // One height counter per column. Out-of-range indices match no column,
  // so they fall out naturally as rejects.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
      logic [CNT_W-1:0] h_d, h_q;

      assign sel_drop[gi]  = (drop_col == COL_W'(gi));
      assign sel_undo[gi]  = (undo_col == COL_W'(gi));
      assign full_vec[gi]  = (h_q == ROWS_C);
      assign empty_vec[gi] = (h_q == '0);
      assign heights_q[gi*CNT_W +: CNT_W] = h_q;

      always_comb begin
        h_d = h_q;
        if (clear) begin
          h_d = '0;
        end else if (dec_vec[gi]) begin
          h_d = h_q - CNT_W'(1);
        end else if (inc_vec[gi]) begin
          h_d = h_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          h_q <= '0;
        end else begin
          h_q <= h_d;
        end
      end
    end
  endgenerate

  // An undo in the same cycle always wins over a drop, whatever the columns.
  always_comb begin
    undo_ok = ~clear & undo_valid & (|(sel_undo & ~empty_vec));
    drop_ok = ~clear & drop_valid & ~undo_valid & (|(sel_drop & ~full_vec));
    inc_vec = sel_drop & {NUM_COLS{drop_ok}};
    dec_vec = sel_undo & {NUM_COLS{undo_ok}};
  end

  always_comb begin
    drop_old_h = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (sel_drop[c]) begin
        drop_old_h = heights_q[c*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    total_d       = total_q;
    drop_row_d    = drop_row_q;
    drop_accept_d = drop_ok;
    drop_reject_d = ~clear & drop_valid & ~drop_ok;
    undo_accept_d = undo_ok;
    undo_reject_d = ~clear & undo_valid & ~undo_ok;
    if (clear) begin
      total_d    = '0;
      drop_row_d = '0;
    end else if (undo_ok) begin
      total_d = total_q - TOT_W'(1);
    end else if (drop_ok) begin
      total_d    = total_q + TOT_W'(1);
      drop_row_d = drop_old_h;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total_q       <= '0;
      drop_row_q    <= '0;
      drop_accept_q <= 1'b0;
      drop_reject_q <= 1'b0;
      undo_accept_q <= 1'b0;
      undo_reject_q <= 1'b0;
    end else begin
      total_q       <= total_d;
      drop_row_q    <= drop_row_d;
      drop_accept_q <= drop_accept_d;
      drop_reject_q <= drop_reject_d;
      undo_accept_q <= undo_accept_d;
      undo_reject_q <= undo_reject_d;
    end
  end

  assign heights     = heights_q;
  assign col_full    = full_vec;
  assign total_count = total_q;
  assign board_full  = (total_q == CELLS_C);
  assign drop_row    = drop_row_q;
  assign drop_accept = drop_accept_q;
  assign drop_reject = drop_reject_q;
  assign undo_accept = undo_accept_q;
  assign undo_reject = undo_reject_q;

endmodule

// File: tb/tb_column_fill_tracker.sv
// Directed bench for column_fill_tracker: default 7x6 board plus a 4x3 instance.
module tb_column_fill_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 7 x 6 instance
  logic        a_clear, a_dv, a_uv;
  logic [3:0]  a_dc, a_uc;
  logic        a_da, a_dr, a_ua, a_ur, a_bf;
  logic [2:0]  a_row;
  logic [20:0] a_h;
  logic [6:0]  a_full;
  logic [5:0]  a_tot;

  // 4 x 3 instance
  logic        b_clear, b_dv, b_uv;
  logic [3:0]  b_dc, b_uc;
  logic        b_da, b_dr, b_ua, b_ur, b_bf;
  logic [1:0]  b_row;
  logic [7:0]  b_h;
  logic [3:0]  b_full;
  logic [3:0]  b_tot;

  int compared   = 0;
  int mismatched = 0;

  column_fill_tracker dut_a (
    .clk(clk), .reset(reset), .clear(a_clear),
    .drop_valid(a_dv), .drop_col(a_dc), .undo_valid(a_uv), .undo_col(a_uc),
    .drop_accept(a_da), .drop_reject(a_dr), .drop_row(a_row),
    .undo_accept(a_ua), .undo_reject(a_ur),
    .heights(a_h), .col_full(a_full), .total_count(a_tot), .board_full(a_bf)
  );

  column_fill_tracker #(.NUM_COLS(4), .NUM_ROWS(3), .COL_W(4)) dut_b (
    .clk(clk), .reset(reset), .clear(b_clear),
    .drop_valid(b_dv), .drop_col(b_dc), .undo_valid(b_uv), .undo_col(b_uc),
    .drop_accept(b_da), .drop_reject(b_dr), .drop_row(b_row),
    .undo_accept(b_ua), .undo_reject(b_ur),
    .heights(b_h), .col_full(b_full), .total_count(b_tot), .board_full(b_bf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses packed as {drop_accept, drop_reject, undo_accept, undo_reject}
  task automatic chk_pa(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, a_da, a_dr, a_ua, a_ur}, {28'd0, exp});
  endtask

  task automatic chk_pb(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, b_da, b_dr, b_ua, b_ur}, {28'd0, exp});
  endtask

  task automatic step_a(input logic clr, input logic dv, input logic [3:0] dc,
                        input logic uv, input logic [3:0] uc);
    a_clear = clr; a_dv = dv; a_dc = dc; a_uv = uv; a_uc = uc;
    @(posedge clk); #1;
    a_clear = 1'b0; a_dv = 1'b0; a_uv = 1'b0;
  endtask

  task automatic step_b(input logic dv, input logic [3:0] dc,
                        input logic uv, input logic [3:0] uc);
    b_dv = dv; b_dc = dc; b_uv = uv; b_uc = uc;
    @(posedge clk); #1;
    b_dv = 1'b0; b_uv = 1'b0;
  endtask

  int eh[7];
  int etot;

  initial begin
    reset = 1'b1;
    a_clear = 0; a_dv = 0; a_uv = 0; a_dc = 0; a_uc = 0;
    b_clear = 0; b_dv = 0; b_uv = 0; b_dc = 0; b_uc = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_heights", {11'd0, a_h}, 32'd0);
    chk("rst_total", {26'd0, a_tot}, 32'd0);
    chk("rst_row", {29'd0, a_row}, 32'd0);
    chk("rst_full", {25'd0, a_full}, 32'd0);
    chk("rst_bfull", {31'd0, a_bf}, 32'd0);
    chk_pa("rst_pulses", 4'b0000);

    // Six drops into column 1
    for (int r = 0; r < 6; r++) begin
      step_a(0, 1, 4'd1, 0, 4'd0);
      $display("drop col1 #%0d: row=%0d total=%0d", r, a_row, a_tot);
      chk_pa("t1_pulse", 4'b1000);
      chk("t1_row", {29'd0, a_row}, r);
      chk("t1_total", {26'd0, a_tot}, r + 1);
    end
    chk("t1_heights", {11'd0, a_h}, 32'd48);
    chk("t1_full", {25'd0, a_full}, 32'h02);

    // Drop into full column
    step_a(0, 1, 4'd1, 0, 4'd0);
    $display("drop col1 full: dr=%0d total=%0d", a_dr, a_tot);
    chk_pa("t2_pulse", 4'b0100);
    chk("t2_heights", {11'd0, a_h}, 32'd48);
    chk("t2_total", {26'd0, a_tot}, 32'd6);
    chk("t2_row_hold", {29'd0, a_row}, 32'd5);
    step_a(0, 0, 4'd0, 0, 4'd0);
    $display("idle: pulses=%b", {a_da, a_dr, a_ua, a_ur});
    chk_pa("t2_idle", 4'b0000);

    // Illegal columns and undo on empty
    step_a(0, 1, 4'd7, 0, 4'd0);
    $display("drop col7: dr=%0d", a_dr);
    chk_pa("t3_col7", 4'b0100);
    step_a(0, 1, 4'd15, 0, 4'd0);
    $display("drop col15: dr=%0d", a_dr);
    chk_pa("t3_col15", 4'b0100);
    chk("t3_heights_a", {11'd0, a_h}, 32'd48);
    step_a(0, 0, 4'd0, 1, 4'd3);
    $display("undo col3 empty: ur=%0d", a_ur);
    chk_pa("t3_undo_empty", 4'b0001);
    step_a(0, 0, 4'd0, 1, 4'd9);
    $display("undo col9: ur=%0d", a_ur);
    chk_pa("t3_undo_col9", 4'b0001);
    chk("t3_heights_b", {11'd0, a_h}, 32'd48);
    chk("t3_total", {26'd0, a_tot}, 32'd6);

    // Simultaneous drop col2 + undo col1
    step_a(0, 1, 4'd2, 1, 4'd1);
    $display("drop2+undo1: pulses=%b heights=%0h total=%0d", {a_da, a_dr, a_ua, a_ur}, a_h, a_tot);
    chk_pa("t4_pulse", 4'b0110);
    chk("t4_heights", {11'd0, a_h}, 32'd40);
    chk("t4_total", {26'd0, a_tot}, 32'd5);
    chk("t4_full", {25'd0, a_full}, 32'd0);

    // Fill the whole board
    foreach (eh[i]) eh[i] = 0;
    eh[1] = 5;
    etot = 5;
    for (int c = 0; c < 7; c++) begin
      while (eh[c] < 6) begin
        step_a(0, 1, 4'(c), 0, 4'd0);
        $display("fill col%0d: row=%0d total=%0d bfull=%0d", c, a_row, a_tot, a_bf);
        chk_pa("t5_pulse", 4'b1000);
        chk("t5_row", {29'd0, a_row}, eh[c]);
        eh[c]++;
        etot++;
        chk("t5_total", {26'd0, a_tot}, etot);
        chk("t5_bfull", {31'd0, a_bf}, (etot == 42) ? 32'd1 : 32'd0);
      end
    end
    chk("t5_heights", {11'd0, a_h}, {11'd0, {7{3'd6}}});
    chk("t5_full", {25'd0, a_full}, 32'h7F);
    step_a(0, 1, 4'd0, 0, 4'd0);
    $display("drop on full board: dr=%0d", a_dr);
    chk_pa("t5_full_reject", 4'b0100);

    // Clear with a concurrent valid undo: no pulse
    step_a(1, 0, 4'd0, 1, 4'd3);
    $display("clear: heights=%0h total=%0d pulses=%b", a_h, a_tot, {a_da, a_dr, a_ua, a_ur});
    chk_pa("t5_clr_pulse", 4'b0000);
    chk("t5_clr_heights", {11'd0, a_h}, 32'd0);
    chk("t5_clr_total", {26'd0, a_tot}, 32'd0);
    chk("t5_clr_bfull", {31'd0, a_bf}, 32'd0);
    chk("t5_clr_row", {29'd0, a_row}, 32'd0);

    // Reset together with a drop
    step_a(0, 1, 4'd4, 0, 4'd0);
    step_a(0, 1, 4'd4, 0, 4'd0);
    $display("drop col4 x2: row=%0d total=%0d", a_row, a_tot);
    chk("t6_row", {29'd0, a_row}, 32'd1);
    chk("t6_heights", {11'd0, a_h}, 32'h2000);
    reset = 1'b1; a_dv = 1'b1; a_dc = 4'd4;
    @(posedge clk); #1;
    reset = 1'b0; a_dv = 1'b0;
    $display("reset+drop: heights=%0h total=%0d pulses=%b", a_h, a_tot, {a_da, a_dr, a_ua, a_ur});
    chk_pa("t6_rst_pulse", 4'b0000);
    chk("t6_rst_heights", {11'd0, a_h}, 32'd0);
    chk("t6_rst_total", {26'd0, a_tot}, 32'd0);
    chk("t6_rst_row", {29'd0, a_row}, 32'd0);

    // 4 x 3 board
    etot = 0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 3; r++) begin
        step_b(1, 4'(c), 0, 4'd0);
        etot++;
        $display("b fill col%0d: row=%0d total=%0d bfull=%0d", c, b_row, b_tot, b_bf);
        chk_pb("b_pulse", 4'b1000);
        chk("b_row", {30'd0, b_row}, r);
        chk("b_total", {28'd0, b_tot}, etot);
        chk("b_bfull", {31'd0, b_bf}, (etot == 12) ? 32'd1 : 32'd0);
      end
      chk("b_full", {28'd0, b_full}, (32'd1 << (c + 1)) - 32'd1);
    end
    step_b(1, 4'd3, 0, 4'd0);
    $display("b drop full col3: dr=%0d", b_dr);
    chk_pb("b_full_reject", 4'b0100);
    step_b(1, 4'd4, 0, 4'd0);
    $display("b drop col4: dr=%0d", b_dr);
    chk_pb("b_col4_reject", 4'b0100);
    step_b(0, 4'd0, 1, 4'd2);
    $display("b undo col2: ua=%0d total=%0d heights=%0h", b_ua, b_tot, b_h);
    chk_pb("b_undo_pulse", 4'b0010);
    chk("b_undo_total", {28'd0, b_tot}, 32'd11);
    chk("b_undo_bfull", {31'd0, b_bf}, 32'd0);
    chk("b_undo_full", {28'd0, b_full}, 32'hB);
    chk("b_undo_heights", {24'd0, b_h}, 32'hEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
